// File: rtl/core_pkg.sv
// -----------------------------------------------------------------------------
// core_pkg
// Shared definitions for the unpipelined RISC-V core front end.
//   fetch_state_e    : fetch sequencer state encoding
//   NOP_INSTR        : canonical NOP (addi x0, x0, 0), shown to decode out of reset
//   RESET_PC_DEFAULT : default first fetch address after reset
//   pc_plus4()       : sequential next-PC, wraps modulo 2^32
// -----------------------------------------------------------------------------
package core_pkg;

  typedef enum logic [2:0] {
    ST_RESET = 3'd0,
    ST_REQ   = 3'd1,
    ST_WAIT  = 3'd2,
    ST_HOLD  = 3'd3,
    ST_FAULT = 3'd4
  } fetch_state_e;

  localparam logic [31:0] NOP_INSTR        = 32'h0000_0013;
  localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;
  localparam logic [31:0] INSTR_BYTES      = 32'd4;

  // Plain 32-bit add; the carry out is dropped so 0xFFFF_FFFC wraps to 0.
  function automatic logic [31:0] pc_plus4(input logic [31:0] pc_i);
    return pc_i + INSTR_BYTES;
  endfunction

endpackage

// File: rtl/fetch_unit_pc_next_sel.sv
// -----------------------------------------------------------------------------
// pc_next_sel
// Combinational next-fetch-address mux.
// Optional feature macro: FETCH_MISALIGN_TRAP_EN
//   fetch_pc_i  in  32  current fetch address
//   pc_src_i    in  1   branch/jump taken for the consumed instruction
//   target_i    in  32  redirect address
//   next_pc_o   out 32  next fetch address
//   misalign_o  out 1   taken redirect to a non-word-aligned target
//                       (only with FETCH_MISALIGN_TRAP_EN)
// -----------------------------------------------------------------------------
module pc_next_sel
  import core_pkg::*;
(
  input  logic [31:0] fetch_pc_i,
  input  logic        pc_src_i,
  input  logic [31:0] target_i,
  output logic [31:0] next_pc_o
`ifdef FETCH_MISALIGN_TRAP_EN
  ,
  output logic        misalign_o
`endif
);

  logic [31:0] seq_pc;
  logic [31:0] redirect_pc;

  assign seq_pc = pc_plus4(fetch_pc_i);

`ifdef FETCH_MISALIGN_TRAP_EN
  // A misaligned target never reaches fetch_pc: the sequencer traps instead.
  assign redirect_pc = target_i;
  assign misalign_o  = pc_src_i & (target_i[1:0] != 2'b00);
`else
  // Without the trap the low bits are simply dropped to keep fetch word aligned.
  logic unused_target_lsb;
  assign unused_target_lsb = ^target_i[1:0];
  assign redirect_pc       = {target_i[31:2], 2'b00};
`endif

  assign next_pc_o = pc_src_i ? redirect_pc : seq_pc;

endmodule

// File: rtl/fetch_unit.sv
// -----------------------------------------------------------------------------
// fetch_unit
// Instruction fetch sequencer: owns the PC, issues one imem request at a time,
// holds the fetched word for decode, and applies the branch decision when
// decode accepts the word.
// Optional feature macro: FETCH_MISALIGN_TRAP_EN (adds FAULT state and
// the misaligned output).
//
//   clk          in  1   core clock
//   rst          in  1   asynchronous active-high reset
//   imem_req     out 1   fetch request
//   imem_addr    out 32  fetch address (word aligned)
//   imem_gnt     in  1   request accepted
//   imem_rvalid  in  1   imem_rdata valid
//   imem_rdata   in  32  fetched word
//   instr        out 32  instruction to decode
//   pc           out 32  address of instr
//   instr_valid  out 1   instr/pc valid
//   instr_ready  in  1   decode consumes instr
//   pc_src       in  1   redirect taken for consumed instruction
//   target       in  32  redirect address
//   misaligned   out 1   sticky fetch fault (FETCH_MISALIGN_TRAP_EN only)
//
// state    | meaning
// ---------+-----------------------------------------------------------
// ST_RESET | in reset; leaves on first edge after rst drops
// ST_REQ   | imem_req high, imem_addr = fetch_pc, waiting for imem_gnt
// ST_WAIT  | request granted, waiting for imem_rvalid
// ST_HOLD  | instr_valid high, waiting for instr_ready handshake
// ST_FAULT | misaligned redirect seen; parked until reset
// -----------------------------------------------------------------------------
module fetch_unit
  import core_pkg::*;
#(
  parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT
) (
  input  logic        clk,
  input  logic        rst,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_gnt,
  input  logic        imem_rvalid,
  input  logic [31:0] imem_rdata,
  output logic [31:0] instr,
  output logic [31:0] pc,
  output logic        instr_valid,
  input  logic        instr_ready,
  input  logic        pc_src,
  input  logic [31:0] target
`ifdef FETCH_MISALIGN_TRAP_EN
  ,
  output logic        misaligned
`endif
);

  fetch_state_e state_q, state_d;
  logic [31:0]  fetch_pc_q, fetch_pc_d;
  logic [31:0]  instr_q, instr_d;
  logic [31:0]  pc_q, pc_d;
  logic [31:0]  next_pc;

`ifdef FETCH_MISALIGN_TRAP_EN
  logic         target_misalign;
`endif

  pc_next_sel u_pc_next_sel (
    .fetch_pc_i (fetch_pc_q),
    .pc_src_i   (pc_src),
    .target_i   (target),
    .next_pc_o  (next_pc)
`ifdef FETCH_MISALIGN_TRAP_EN
    ,
    .misalign_o (target_misalign)
`endif
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= ST_RESET;
      fetch_pc_q <= RESET_PC;
      instr_q    <= NOP_INSTR;
      pc_q       <= RESET_PC;
    end else begin
      state_q    <= state_d;
      fetch_pc_q <= fetch_pc_d;
      instr_q    <= instr_d;
      pc_q       <= pc_d;
    end
  end

  // rvalid/gnt outside their own state fall through untouched, which is what
  // discards responses still in flight across a reset.
  always_comb begin
    state_d    = state_q;
    fetch_pc_d = fetch_pc_q;
    instr_d    = instr_q;
    pc_d       = pc_q;
    unique case (state_q)
      ST_RESET: state_d = ST_REQ;
      ST_REQ: begin
        if (imem_gnt) state_d = ST_WAIT;
      end
      ST_WAIT: begin
        if (imem_rvalid) begin
          instr_d = imem_rdata;
          pc_d    = fetch_pc_q;
          state_d = ST_HOLD;
        end
      end
      ST_HOLD: begin
        if (instr_ready) begin
`ifdef FETCH_MISALIGN_TRAP_EN
          if (target_misalign) begin
            state_d = ST_FAULT;
          end else begin
            fetch_pc_d = next_pc;
            state_d    = ST_REQ;
          end
`else
          fetch_pc_d = next_pc;
          state_d    = ST_REQ;
`endif
        end
      end
`ifdef FETCH_MISALIGN_TRAP_EN
      ST_FAULT: state_d = ST_FAULT;
`endif
      default: state_d = ST_RESET;
    endcase
  end

  // Outputs come straight from registers or state decode only.
  assign imem_req    = (state_q == ST_REQ);
  assign imem_addr   = fetch_pc_q;
  assign instr       = instr_q;
  assign pc          = pc_q;
  assign instr_valid = (state_q == ST_HOLD);
`ifdef FETCH_MISALIGN_TRAP_EN
  assign misaligned  = (state_q == ST_FAULT);
`endif

endmodule
